hack_kbd_ctrl: RTL and testbench
================================

# hack_kbd_ctrl

Parametrised PS/2-to-Hack keyboard controller that replaces the inline scancode-to-ASCII decoder in the Hack MiSTer top level. It sits between the `hps_io` `ps2_key` bus and the Memory block's KBD register (0x6000). It tracks Shift state, extended keys and several simultaneously held keys, so that releasing one key reveals the one still held. It also queues every press, including typematic repeats, in an event FIFO for later consumers.

## Interface
- `OUT_W`, default 16: width of `kbd_code` and `ev_code`; codes are zero-extended to this width. Minimum 8.
- `HOLD_DEPTH`, default 4: number of simultaneously held mapped keys tracked. Range 1–8.
- `FIFO_DEPTH`, default 8: event FIFO entries. Must be a power of two, at least 2.

Ports (clock and reset first):
- `clk_sys`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_key`  in  11  `hps_io` key bus:
  - [10] toggles once per key event.
  - [9] is 1 on press, 0 on release.
  - [8] is the E0-extended flag.
  - [7:0] is the scancode.
- `kbd_code`  out  OUT_W  Hack key code of the most recently pressed key still held; 0 when none is held.
- `shift`  out  1  1 while either Shift key is held.
- `ev_valid`  out  1  event FIFO not empty.
- `ev_code`  out  OUT_W  code at the FIFO head; valid only while `ev_valid` = 1.
- `ev_ready`  in  1  consumer accepts the head entry.
- `ev_ovf`  out  1  sticky flag: an event was dropped because the FIFO was full. Cleared only by `reset`.

## Operation
- **Edge detect.** A registered copy `tog_q` of `ps2_key[10]` is kept. An event is captured when `ps2_key[10] != tog_q`; `ps2_key[9:0]` is latched on that edge.
- **Modifiers.**
  - Non-extended 0x12 or 0x59 sets/clears the Left/Right Shift bit according to [9].
  - Shift bits never enter the hold stack or the FIFO.
  - Ctrl (0x14) and Alt (0x11) are ignored, whether extended or not.
- **Translation.** Codes follow the Hack standard.
  - Unshifted:
    - a–z and 0–9: ASCII.
    - Space: 32.
    - `- = [ ] ; ' , . / \` and backtick: ASCII.
    - Keypad + - * /: ASCII.
    - Enter (0x5A, extended or not): 128.
    - Backspace: 129.
    - Escape: 140.
    - F1–F12: 141–152.
  - Extended:
    - Left 130, Up 131, Right 132, Down 133.
    - Home 134, End 135, PgUp 136, PgDn 137.
    - Insert 138, Delete 139.
  - With Shift held:
    - Letters become A–Z.
    - The number row and punctuation use the US layout (`1`→`!` … `0`→`)`, `-`→`_`, `/`→`?` and so on).
  - Any other scancode translates to 0 and is unmapped. Unmapped keys affect nothing.
- **Hold stack.** Each entry holds {ext, scancode, code}; entry 0 is the top.
  - Mapped press, key not present: shift entries down and insert at the top. When the stack is full, the bottom entry is discarded.
  - Mapped press, key already present: the stack is unchanged and no entry is duplicated.
  - Release: remove the entry whose {ext, scancode} matches, regardless of the current Shift state, and compact upward. A release of a key not in the stack does nothing.
  - `kbd_code` is the top entry's code (the code stored at press time), or 0 when the stack is empty.
- **Event FIFO.**
  - Every mapped press, including repeats of a held key, pushes its translated code.
  - Pop occurs when `ev_valid && ev_ready`.
  - Push when full: the event is dropped and `ev_ovf` is set.
  - Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle when empty is impossible, because `ev_valid` = 0.

## Timing
- **Reset.** On a cycle with `reset` = 1:
  - `kbd_code` = 0, `shift` = 0, `ev_valid` = 0, `ev_ovf` = 0, `ev_code` = 0.
  - Stack and FIFO are emptied.
  - `tog_q` loads the current `ps2_key[10]`, so no spurious event follows reset.
  - An event in flight during reset is discarded.
- **Pipeline.** Let edge N be the first rising edge at which `ps2_key[10] != tog_q`.
  - Edge N: capture.
  - Edge N+1: translate and register the result.
  - Edge N+2: stack, `shift`, FIFO and `kbd_code` update; `ev_valid` rises after edge N+2 if the FIFO was empty.
- **Throughput.** One event per cycle, sustained. Back-to-back toggles on consecutive cycles are each processed in order.
- **Stack interaction.** A press and a release arriving in consecutive cycles see each other's stack updates; there is no hazard.
- **FIFO registers.** `ev_code` is registered, and a new head is presented the cycle after a pop.

## Test plan
- **Basic press/release.** Press `a` (0x1C) and hold.
  - `kbd_code` = 97 two cycles after the toggle; `ev_valid` = 1 with `ev_code` = 97.
  - Release: `kbd_code` = 0 two cycles after the toggle.
- **Shift and extended keys.**
  - Press 0x12, then 0x16 → `shift` = 1, `kbd_code` = 33 (`!`).
  - Release 0x12 while `1` is still held → `kbd_code` stays 33.
  - Extended 0x75 → 131.
- **Overlapping holds.** Press `a`, `b`, `c`, then release `c` → `kbd_code` goes 97 → 98 → 99 → 98. Release `a`, then `b` → 98, then 0.
- **Stack overflow.** With HOLD_DEPTH = 4, press five keys 1–5.
  - `kbd_code` = 53.
  - Releasing `5`, `4`, `3`, `2` gives 52, 51, 50, then 0, because `1` was evicted.
- **FIFO overflow.** Hold `ev_ready` = 0 and send 9 presses with FIFO_DEPTH = 8.
  - Eight codes drain in order and `ev_ovf` = 1.
  - On the next event with the FIFO full and `ev_ready` = 1, the push and pop both succeed and the count stays 8.
- **Reset mid-operation.** Hold a key, then assert `reset` on the capture cycle.
  - All outputs are 0 after reset and no event appears.
  - Typematic repeat toggles of the held key push repeat codes.

Source files
------------

// File: rtl/hack_kbd_ctrl.sv
// rtl/hack_kbd_ctrl.sv - ps2_key bus to Hack KBD code with a hold stack and a press event FIFO
// Three stages: capture on toggle, translate, then apply to shift/stack/FIFO.
module hack_kbd_ctrl #(
  parameter int OUT_W      = 16,
  parameter int HOLD_DEPTH = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic [10:0]      ps2_key,
  output logic [OUT_W-1:0] kbd_code,
  output logic             shift,
  output logic             ev_valid,
  output logic [OUT_W-1:0] ev_code,
  input  logic             ev_ready,
  output logic             ev_ovf
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  function automatic logic [7:0] xlate(input logic ext, input logic [7:0] sc, input logic sh);
    logic [7:0] c;
    c = 8'd0;
    if (ext) begin
      case (sc)
        8'h5A: c = 8'd128;
        8'h4A: c = 8'd47;
        8'h6B: c = 8'd130;
        8'h75: c = 8'd131;
        8'h74: c = 8'd132;
        8'h72: c = 8'd133;
        8'h6C: c = 8'd134;
        8'h69: c = 8'd135;
        8'h7D: c = 8'd136;
        8'h7A: c = 8'd137;
        8'h70: c = 8'd138;
        8'h71: c = 8'd139;
        default: c = 8'd0;
      endcase
    end else begin
      case (sc)
        8'h1C: c = 8'd97;   8'h32: c = 8'd98;   8'h21: c = 8'd99;   8'h23: c = 8'd100;
        8'h24: c = 8'd101;  8'h2B: c = 8'd102;  8'h34: c = 8'd103;  8'h33: c = 8'd104;
        8'h43: c = 8'd105;  8'h3B: c = 8'd106;  8'h42: c = 8'd107;  8'h4B: c = 8'd108;
        8'h3A: c = 8'd109;  8'h31: c = 8'd110;  8'h44: c = 8'd111;  8'h4D: c = 8'd112;
        8'h15: c = 8'd113;  8'h2D: c = 8'd114;  8'h1B: c = 8'd115;  8'h2C: c = 8'd116;
        8'h3C: c = 8'd117;  8'h2A: c = 8'd118;  8'h1D: c = 8'd119;  8'h22: c = 8'd120;
        8'h35: c = 8'd121;  8'h1A: c = 8'd122;
        8'h16: c = sh ? 8'd33  : 8'd49;
        8'h1E: c = sh ? 8'd64  : 8'd50;
        8'h26: c = sh ? 8'd35  : 8'd51;
        8'h25: c = sh ? 8'd36  : 8'd52;
        8'h2E: c = sh ? 8'd37  : 8'd53;
        8'h36: c = sh ? 8'd94  : 8'd54;
        8'h3D: c = sh ? 8'd38  : 8'd55;
        8'h3E: c = sh ? 8'd42  : 8'd56;
        8'h46: c = sh ? 8'd40  : 8'd57;
        8'h45: c = sh ? 8'd41  : 8'd48;
        8'h4E: c = sh ? 8'd95  : 8'd45;
        8'h55: c = sh ? 8'd43  : 8'd61;
        8'h54: c = sh ? 8'd123 : 8'd91;
        8'h5B: c = sh ? 8'd125 : 8'd93;
        8'h4C: c = sh ? 8'd58  : 8'd59;
        8'h52: c = sh ? 8'd34  : 8'd39;
        8'h41: c = sh ? 8'd60  : 8'd44;
        8'h49: c = sh ? 8'd62  : 8'd46;
        8'h4A: c = sh ? 8'd63  : 8'd47;
        8'h5D: c = sh ? 8'd124 : 8'd92;
        8'h0E: c = sh ? 8'd126 : 8'd96;
        8'h29: c = 8'd32;
        8'h79: c = 8'd43;   8'h7B: c = 8'd45;   8'h7C: c = 8'd42;
        8'h5A: c = 8'd128;  8'h66: c = 8'd129;  8'h76: c = 8'd140;
        8'h05: c = 8'd141;  8'h06: c = 8'd142;  8'h04: c = 8'd143;  8'h0C: c = 8'd144;
        8'h03: c = 8'd145;  8'h0B: c = 8'd146;  8'h83: c = 8'd147;  8'h0A: c = 8'd148;
        8'h01: c = 8'd149;  8'h09: c = 8'd150;  8'h78: c = 8'd151;  8'h07: c = 8'd152;
        default: c = 8'd0;
      endcase
      // Shifted punctuation lands outside a..z, so only letters are folded to upper case
      if (sh && c >= 8'd97 && c <= 8'd122) c = c - 8'd32;
    end
    return c;
  endfunction

  logic       tog_q, cap_valid;
  logic [9:0] cap_key;
  logic       t_valid, t_press, t_ext, t_shl, t_shr;
  logic [7:0] t_scan, t_code;
  logic       shift_l, shift_r, shift_l_n, shift_r_n;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q     <= ps2_key[10];
      cap_valid <= 1'b0;
      cap_key   <= '0;
    end else begin
      tog_q     <= ps2_key[10];
      cap_valid <= (ps2_key[10] != tog_q);
      cap_key   <= ps2_key[9:0];
    end
  end

  // Translation sees the shift state that the event ahead of it is about to apply
  assign shift_l_n = (t_valid && t_shl) ? t_press : shift_l;
  assign shift_r_n = (t_valid && t_shr) ? t_press : shift_r;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      t_valid <= 1'b0;
      t_press <= 1'b0;
      t_ext   <= 1'b0;
      t_scan  <= '0;
      t_code  <= '0;
      t_shl   <= 1'b0;
      t_shr   <= 1'b0;
    end else begin
      t_valid <= cap_valid;
      t_press <= cap_key[9];
      t_ext   <= cap_key[8];
      t_scan  <= cap_key[7:0];
      t_code  <= xlate(cap_key[8], cap_key[7:0], shift_l_n | shift_r_n);
      t_shl   <= cap_valid && !cap_key[8] && (cap_key[7:0] == 8'h12);
      t_shr   <= cap_valid && !cap_key[8] && (cap_key[7:0] == 8'h59);
    end
  end

  logic [HOLD_DEPTH-1:0] st_vld, st_vld_n, hit;
  logic [8:0]            st_key    [HOLD_DEPTH];
  logic [8:0]            st_key_n  [HOLD_DEPTH];
  logic [7:0]            st_code   [HOLD_DEPTH];
  logic [7:0]            st_code_n [HOLD_DEPTH];
  logic [HOLD_DEPTH:0]   vld_x;
  logic [8:0]            key_x     [HOLD_DEPTH+1];
  logic [7:0]            code_x    [HOLD_DEPTH+1];
  logic                  seen, mapped, do_ins, do_rem;

  always_comb begin
    hit   = '0;
    vld_x = '0;
    for (int i = 0; i <= HOLD_DEPTH; i++) begin
      key_x[i]  = '0;
      code_x[i] = '0;
    end
    for (int i = 0; i < HOLD_DEPTH; i++) begin
      hit[i]    = st_vld[i] && (st_key[i] == {t_ext, t_scan});
      vld_x[i]  = st_vld[i];
      key_x[i]  = st_key[i];
      code_x[i] = st_code[i];
    end
    mapped    = (t_code != 8'd0);
    do_ins    = t_valid && t_press && mapped && !(|hit);
    do_rem    = t_valid && !t_press && (|hit);
    st_vld_n  = st_vld;
    st_key_n  = st_key;
    st_code_n = st_code;
    seen      = 1'b0;
    if (do_ins) begin
      for (int i = 1; i < HOLD_DEPTH; i++) begin
        st_vld_n[i]  = st_vld[i-1];
        st_key_n[i]  = st_key[i-1];
        st_code_n[i] = st_code[i-1];
      end
      st_vld_n[0]  = 1'b1;
      st_key_n[0]  = {t_ext, t_scan};
      st_code_n[0] = t_code;
    end else if (do_rem) begin
      // Everything from the matching slot down moves up one place
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        seen = seen | hit[i];
        if (seen) begin
          st_vld_n[i]  = vld_x[i+1];
          st_key_n[i]  = key_x[i+1];
          st_code_n[i] = code_x[i+1];
        end
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      st_vld <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) begin
        st_key[i]  <= '0;
        st_code[i] <= '0;
      end
    end else begin
      st_vld  <= st_vld_n;
      st_key  <= st_key_n;
      st_code <= st_code_n;
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n;
  logic [CW-1:0] count, count_n;
  logic [7:0]    head_q, head_n;
  logic          push_req, push, pop, full;

  always_comb begin
    full     = (count == CW'(FIFO_DEPTH));
    pop      = (count != '0) && ev_ready;
    push_req = t_valid && t_press && mapped;
    push     = push_req && (!full || pop);
    rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;
    count_n  = count;
    head_n   = '0;
    if (push && !pop)      count_n = count + CW'(1);
    else if (pop && !push) count_n = count - CW'(1);
    // The entry being written becomes the head only when nothing older survives the pop
    if (count_n == '0)                                head_n = '0;
    else if (count == '0 || (count == CW'(1) && pop)) head_n = t_code;
    else                                              head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      head_q  <= '0;
      ev_ovf  <= 1'b0;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
    end else begin
      rd_ptr  <= rd_ptr_n;
      count   <= count_n;
      head_q  <= head_n;
      shift_l <= shift_l_n;
      shift_r <= shift_r_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (push_req && !push) ev_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= t_code;
  end

  assign kbd_code = st_vld[0] ? OUT_W'(st_code[0]) : '0;
  assign shift    = shift_l | shift_r;
  assign ev_valid = (count != '0);
  assign ev_code  = OUT_W'(head_q);

endmodule

// File: tb/tb_hack_kbd_ctrl.sv
// tb/tb_hack_kbd_ctrl.sv - directed self-checking bench for hack_kbd_ctrl
module tb_hack_kbd_ctrl;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] kbd_code;
  logic        shift;
  logic        ev_valid;
  logic [15:0] ev_code;
  logic        ev_ready;
  logic        ev_ovf;
  int          vectors = 0;
  int          errors  = 0;
  logic [15:0] exp_q [8];

  always #5 clk_sys = ~clk_sys;

  hack_kbd_ctrl #(.OUT_W(16), .HOLD_DEPTH(4), .FIFO_DEPTH(8)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_key  (ps2_key),
    .kbd_code (kbd_code),
    .shift    (shift),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ready (ev_ready),
    .ev_ovf   (ev_ovf)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic key(input logic p, input logic e, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], p, e, sc};
    tick(3);
  endtask

  initial begin
    exp_q[0] = 16'd98;  exp_q[1] = 16'd99;  exp_q[2] = 16'd100; exp_q[3] = 16'd101;
    exp_q[4] = 16'd102; exp_q[5] = 16'd103; exp_q[6] = 16'd104; exp_q[7] = 16'd106;

    reset    = 1'b1;
    ps2_key  = 11'h400;
    ev_ready = 1'b1;
    tick(2);
    chk16("rst_kbd", kbd_code, 16'd0);
    chk1 ("rst_shift", shift, 1'b0);
    chk1 ("rst_valid", ev_valid, 1'b0);
    chk16("rst_evcode", ev_code, 16'd0);
    chk1 ("rst_ovf", ev_ovf, 1'b0);
    reset = 1'b0;
    tick(3);
    chk1 ("no_spurious", ev_valid, 1'b0);

    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    tick(2);
    chk16("a_latency", kbd_code, 16'd0);
    tick(1);
    chk16("a_press", kbd_code, 16'd97);
    chk1 ("a_valid", ev_valid, 1'b1);
    chk16("a_evcode", ev_code, 16'd97);
    key(1'b0, 1'b0, 8'h1C);
    chk16("a_release", kbd_code, 16'd0);
    chk1 ("a_popped", ev_valid, 1'b0);

    key(1'b1, 1'b0, 8'h12);
    chk1 ("lshift_on", shift, 1'b1);
    chk1 ("lshift_nopush", ev_valid, 1'b0);
    key(1'b1, 1'b0, 8'h16);
    chk16("bang", kbd_code, 16'd33);
    chk16("bang_ev", ev_code, 16'd33);
    key(1'b0, 1'b0, 8'h12);
    chk1 ("lshift_off", shift, 1'b0);
    chk16("bang_kept", kbd_code, 16'd33);
    key(1'b0, 1'b0, 8'h16);
    chk16("bang_rel", kbd_code, 16'd0);
    key(1'b1, 1'b1, 8'h75);
    chk16("up_arrow", kbd_code, 16'd131);
    key(1'b0, 1'b1, 8'h75);
    chk16("up_rel", kbd_code, 16'd0);
    key(1'b1, 1'b0, 8'h75);
    chk16("unmapped_kbd", kbd_code, 16'd0);
    chk1 ("unmapped_ev", ev_valid, 1'b0);
    key(1'b0, 1'b0, 8'h75);

    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h59};
    tick(1);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1E};
    tick(3);
    chk16("b2b_at", kbd_code, 16'd64);
    chk1 ("b2b_rshift", shift, 1'b1);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h1E};
    tick(1);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h59};
    tick(3);
    chk16("b2b_rel", kbd_code, 16'd0);
    chk1 ("b2b_shift_off", shift, 1'b0);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    tick(1);
    ps2_key = {~ps2_key[10], 1'b0, 1'b0, 8'h1C};
    tick(3);
    chk16("b2b_press_rel", kbd_code, 16'd0);

    key(1'b1, 1'b0, 8'h1C);
    chk16("ov_a", kbd_code, 16'd97);
    key(1'b1, 1'b0, 8'h32);
    chk16("ov_b", kbd_code, 16'd98);
    key(1'b1, 1'b0, 8'h21);
    chk16("ov_c", kbd_code, 16'd99);
    key(1'b0, 1'b0, 8'h21);
    chk16("ov_rel_c", kbd_code, 16'd98);
    key(1'b0, 1'b0, 8'h1C);
    chk16("ov_rel_a", kbd_code, 16'd98);
    key(1'b0, 1'b0, 8'h32);
    chk16("ov_rel_b", kbd_code, 16'd0);

    key(1'b1, 1'b0, 8'h16);
    key(1'b1, 1'b0, 8'h1E);
    key(1'b1, 1'b0, 8'h26);
    key(1'b1, 1'b0, 8'h25);
    key(1'b1, 1'b0, 8'h2E);
    chk16("stk_five", kbd_code, 16'd53);
    key(1'b0, 1'b0, 8'h2E);
    chk16("stk_rel5", kbd_code, 16'd52);
    key(1'b0, 1'b0, 8'h25);
    chk16("stk_rel4", kbd_code, 16'd51);
    key(1'b0, 1'b0, 8'h26);
    chk16("stk_rel3", kbd_code, 16'd50);
    key(1'b0, 1'b0, 8'h1E);
    chk16("stk_rel2", kbd_code, 16'd0);
    key(1'b0, 1'b0, 8'h16);
    chk16("stk_rel1", kbd_code, 16'd0);
    chk1 ("stk_drained", ev_valid, 1'b0);

    ev_ready = 1'b0;
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h32);
    key(1'b1, 1'b0, 8'h21);
    key(1'b1, 1'b0, 8'h23);
    key(1'b1, 1'b0, 8'h24);
    key(1'b1, 1'b0, 8'h2B);
    key(1'b1, 1'b0, 8'h34);
    key(1'b1, 1'b0, 8'h33);
    chk1 ("fifo_full_no_ovf", ev_ovf, 1'b0);
    key(1'b1, 1'b0, 8'h43);
    chk1 ("fifo_ovf", ev_ovf, 1'b1);
    chk16("fifo_head", ev_code, 16'd97);
    chk16("fifo_kbd", kbd_code, 16'd105);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h3B};
    tick(2);
    ev_ready = 1'b1;
    tick(1);
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk1 ("drain_valid", ev_valid, 1'b1);
      chk16("drain_code", ev_code, exp_q[i]);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
    end
    chk1 ("drain_empty", ev_valid, 1'b0);
    chk1 ("ovf_sticky", ev_ovf, 1'b1);

    ev_ready = 1'b1;
    key(1'b1, 1'b0, 8'h1C);
    chk16("pre_reset_hold", kbd_code, 16'd97);
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk16("mid_rst_kbd", kbd_code, 16'd0);
    chk1 ("mid_rst_ovf", ev_ovf, 1'b0);
    chk1 ("mid_rst_valid", ev_valid, 1'b0);
    chk16("mid_rst_evcode", ev_code, 16'd0);
    tick(3);
    chk1 ("post_rst_no_ev", ev_valid, 1'b0);
    chk16("post_rst_kbd", kbd_code, 16'd0);

    ev_ready = 1'b0;
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h1C);
    key(1'b1, 1'b0, 8'h1C);
    chk16("rep_kbd", kbd_code, 16'd97);
    for (int i = 0; i < 3; i++) begin
      chk1 ("rep_valid", ev_valid, 1'b1);
      chk16("rep_code", ev_code, 16'd97);
      ev_ready = 1'b1;
      tick(1);
      ev_ready = 1'b0;
    end
    chk1 ("rep_empty", ev_valid, 1'b0);
    key(1'b0, 1'b0, 8'h1C);
    chk16("rep_rel", kbd_code, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
